// File: rtl/reg_file_scb_pkg.sv
// rtl/reg_file_scb_pkg.sv - shared definitions for the FASA register file and load scoreboard
package reg_file_scb_pkg;

  // Per-register load scoreboard state
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } busy_state_e;

  // Architectural zero register index
  localparam int kRegZero = 0;

  // Opcode constants used by decode to drive LdIssue / WenAlu
  localparam logic [3:0] kALU = 4'h0;
  localparam logic [3:0] kLOD = 4'h1;
  localparam logic [3:0] kSTO = 4'h2;
  localparam logic [3:0] kBRA = 4'h3;
  localparam logic [3:0] kJMP = 4'h4;

  // Opcodes whose destination is filled by the memory return path
  function automatic logic is_load_op(input logic [3:0] op);
    return (op == kLOD);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register load busy tracking, pending count and stray-return detection
module reg_scoreboard
  import reg_file_scb_pkg::*;
#(
  parameter int A       = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  input  logic         WenAlu,
  input  logic [A-1:0] WaddrAlu,
  input  logic         LdIssue,
  input  logic [A-1:0] LdAddr,
  input  logic         LdRet,
  input  logic [A-1:0] LdRetAddr,
  output logic         RetWe,
  output logic         Stall,
  output logic         IssueStall,
  output logic [A:0]   Pending,
  output logic         ErrSticky
);

  localparam int N = 1 << A;

  busy_state_e state_q [N];
  logic [N-1:0] busy;
  logic alu_v, issue_v, ret_v;
  logic clr_alu, clr_ret, dec_ret, issue_ok, stray;
  logic clr_a, clr_b;

  // Flatten per-register state into a busy vector for indexing
  always_comb begin
    busy = '0;
    for (int i = 0; i < N; i++) busy[i] = (state_q[i] == BUSY);
  end

  // Qualify requests, detect clears, issue acceptance and stray returns
  always_comb begin
    alu_v    = WenAlu  && !((ZERO_R0 != 0) && (WaddrAlu  == A'(kRegZero)));
    issue_v  = LdIssue && !((ZERO_R0 != 0) && (LdAddr    == A'(kRegZero)));
    ret_v    = LdRet   && !((ZERO_R0 != 0) && (LdRetAddr == A'(kRegZero)));
    clr_alu  = alu_v && busy[WaddrAlu];
    clr_ret  = ret_v && busy[LdRetAddr];
    stray    = ret_v && !busy[LdRetAddr];
    // A register being cleared this cycle may be re-issued without stalling
    issue_ok = issue_v && (!busy[LdAddr] ||
                           (clr_alu && (WaddrAlu  == LdAddr)) ||
                           (clr_ret && (LdRetAddr == LdAddr)));
    IssueStall = issue_v && !issue_ok;
    RetWe      = clr_ret;
    // Both ports clearing the same register is a single decrement
    dec_ret  = clr_ret && !(clr_alu && (WaddrAlu == LdRetAddr));
    // A read that picks up this cycle's clearing write is not busy
    clr_a = (BYPASS != 0) && ((clr_alu && (WaddrAlu == RaddrA)) ||
                              (clr_ret && (LdRetAddr == RaddrA)));
    clr_b = (BYPASS != 0) && ((clr_alu && (WaddrAlu == RaddrB)) ||
                              (clr_ret && (LdRetAddr == RaddrB)));
    Stall = (busy[RaddrA] && !clr_a) || (busy[RaddrB] && !clr_b);
  end

  // Busy FSMs, pending counter and sticky stray-return flag
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < N; i++) state_q[i] <= IDLE;
      Pending   <= '0;
      ErrSticky <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (issue_ok && (LdAddr == A'(i))) begin
          state_q[i] <= BUSY;
        end else if ((clr_alu && (WaddrAlu == A'(i))) ||
                     (clr_ret && (LdRetAddr == A'(i)))) begin
          state_q[i] <= IDLE;
        end
      end
      Pending <= Pending + (A+1)'(issue_ok) - (A+1)'(clr_alu) - (A+1)'(dec_ret);
      if (stray) ErrSticky <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_scb.sv
// rtl/reg_file_scb.sv - two-read, two-write register file with bypass and load scoreboard
module reg_file_scb
  import reg_file_scb_pkg::*;
#(
  parameter int W       = 8,
  parameter int A       = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         WenAlu,
  input  logic [A-1:0] WaddrAlu,
  input  logic [W-1:0] WdataAlu,
  input  logic         LdIssue,
  input  logic [A-1:0] LdAddr,
  input  logic         LdRet,
  input  logic [A-1:0] LdRetAddr,
  input  logic [W-1:0] LdRetData,
  output logic         Stall,
  output logic         IssueStall,
  output logic [A:0]   Pending,
  output logic         ErrSticky
);

  localparam int N = 1 << A;

  logic [W-1:0] regs_q [N];
  logic ret_accept, alu_we, ret_we;

  reg_scoreboard #(.A(A), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_scb (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .RaddrA     (RaddrA),
    .RaddrB     (RaddrB),
    .WenAlu     (WenAlu),
    .WaddrAlu   (WaddrAlu),
    .LdIssue    (LdIssue),
    .LdAddr     (LdAddr),
    .LdRet      (LdRet),
    .LdRetAddr  (LdRetAddr),
    .RetWe      (ret_accept),
    .Stall      (Stall),
    .IssueStall (IssueStall),
    .Pending    (Pending),
    .ErrSticky  (ErrSticky)
  );

  // Read mux: r0 forced to zero, then ALU bypass, then load-return bypass, then storage
  function automatic logic [W-1:0] read_mux(
    input logic [A-1:0] ra,
    input logic [W-1:0] stored,
    input logic         a_we,
    input logic [A-1:0] a_addr,
    input logic [W-1:0] a_data,
    input logic         r_we,
    input logic [A-1:0] r_addr,
    input logic [W-1:0] r_data
  );
    if ((ZERO_R0 != 0) && (ra == A'(kRegZero))) return '0;
    if ((BYPASS != 0) && a_we && (a_addr == ra)) return a_data;
    if ((BYPASS != 0) && r_we && (r_addr == ra)) return r_data;
    return stored;
  endfunction

  // Write arbitration: ALU is program-younger and wins a same-address collision
  always_comb begin
    alu_we = WenAlu && !((ZERO_R0 != 0) && (WaddrAlu == A'(kRegZero)));
    ret_we = ret_accept && !(alu_we && (WaddrAlu == LdRetAddr));
    DataOutA = read_mux(RaddrA, regs_q[RaddrA], alu_we, WaddrAlu, WdataAlu,
                        ret_we, LdRetAddr, LdRetData);
    DataOutB = read_mux(RaddrB, regs_q[RaddrB], alu_we, WaddrAlu, WdataAlu,
                        ret_we, LdRetAddr, LdRetData);
  end

  // Register storage
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else begin
      if (alu_we) regs_q[WaddrAlu]  <= WdataAlu;
      if (ret_we) regs_q[LdRetAddr] <= LdRetData;
    end
  end

endmodule

// File: tb/tb_reg_file_scb.sv
// tb/tb_reg_file_scb.sv - directed self-checking bench for reg_file_scb
module tb_reg_file_scb;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic [3:0] RaddrA, RaddrB, WaddrAlu, LdAddr, LdRetAddr;
  logic [7:0] WdataAlu, LdRetData;
  logic       WenAlu, LdIssue, LdRet;

  logic [7:0] DataOutA, DataOutB, nb_DataOutA, nb_DataOutB;
  logic       Stall, IssueStall, ErrSticky;
  logic       nb_Stall, nb_IssueStall, nb_ErrSticky;
  logic [4:0] Pending, nb_Pending;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  reg_file_scb #(.W(8), .A(4), .ZERO_R0(1), .BYPASS(1)) dut (
    .Clk(Clk), .ResetN(ResetN), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(DataOutA), .DataOutB(DataOutB),
    .WenAlu(WenAlu), .WaddrAlu(WaddrAlu), .WdataAlu(WdataAlu),
    .LdIssue(LdIssue), .LdAddr(LdAddr), .LdRet(LdRet),
    .LdRetAddr(LdRetAddr), .LdRetData(LdRetData),
    .Stall(Stall), .IssueStall(IssueStall), .Pending(Pending), .ErrSticky(ErrSticky)
  );

  reg_file_scb #(.W(8), .A(4), .ZERO_R0(0), .BYPASS(0)) dut_nb (
    .Clk(Clk), .ResetN(ResetN), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(nb_DataOutA), .DataOutB(nb_DataOutB),
    .WenAlu(WenAlu), .WaddrAlu(WaddrAlu), .WdataAlu(WdataAlu),
    .LdIssue(LdIssue), .LdAddr(LdAddr), .LdRet(LdRet),
    .LdRetAddr(LdRetAddr), .LdRetData(LdRetData),
    .Stall(nb_Stall), .IssueStall(nb_IssueStall), .Pending(nb_Pending),
    .ErrSticky(nb_ErrSticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    ResetN = 1'b0;
    RaddrA = 4'd0; RaddrB = 4'd0;
    WenAlu = 1'b0; WaddrAlu = 4'd0; WdataAlu = 8'h00;
    LdIssue = 1'b0; LdAddr = 4'd0;
    LdRet = 1'b0; LdRetAddr = 4'd0; LdRetData = 8'h00;
    #2;
    check("rst_douta",   32'(DataOutA), 32'h00);
    check("rst_pending", 32'(Pending), 32'd0);
    check("rst_err",     32'(ErrSticky), 32'd0);
    check("rst_stall",   32'(Stall), 32'd0);
    check("rst_istall",  32'(IssueStall), 32'd0);
    ResetN = 1'b1;

    // r5 = 0x3C for the mid-run reset check at the end
    tick;
    WenAlu = 1'b1; WaddrAlu = 4'd5; WdataAlu = 8'h3C;
    tick;
    WenAlu = 1'b0; RaddrA = 4'd5;
    #1 check("wr_r5", 32'(DataOutA), 32'h3C);

    // Bypass of a same-cycle ALU write
    WenAlu = 1'b1; WaddrAlu = 4'd4; WdataAlu = 8'hA5; RaddrA = 4'd4; RaddrB = 4'd4;
    #1;
    check("byp_a",      32'(DataOutA), 32'hA5);
    check("nobyp_old",  32'(nb_DataOutA), 32'h00);
    tick;
    WenAlu = 1'b0;
    #1;
    check("nobyp_new",  32'(nb_DataOutA), 32'hA5);
    check("byp_after",  32'(DataOutA), 32'hA5);

    // Scoreboard round trip on r7
    LdIssue = 1'b1; LdAddr = 4'd7;
    #1 check("sb_istall0", 32'(IssueStall), 32'd0);
    tick;
    LdIssue = 1'b0;
    #1 check("sb_pend1", 32'(Pending), 32'd1);
    RaddrB = 4'd7;
    #1 check("sb_stall1", 32'(Stall), 32'd1);
    LdRet = 1'b1; LdRetAddr = 4'd7; LdRetData = 8'h5A;
    #1;
    check("sb_byp_stall", 32'(Stall), 32'd0);
    check("sb_byp_doutb", 32'(DataOutB), 32'h5A);
    check("nb_stall",     32'(nb_Stall), 32'd1);
    tick;
    LdRet = 1'b0;
    #1;
    check("sb_stall0", 32'(Stall), 32'd0);
    check("sb_doutb",  32'(DataOutB), 32'h5A);
    check("sb_pend0",  32'(Pending), 32'd0);
    check("sb_err0",   32'(ErrSticky), 32'd0);

    // ALU write and load return collide on busy r2
    LdIssue = 1'b1; LdAddr = 4'd2;
    tick;
    LdIssue = 1'b0;
    #1 check("cf_pend1", 32'(Pending), 32'd1);
    WenAlu = 1'b1; WaddrAlu = 4'd2; WdataAlu = 8'h11;
    LdRet = 1'b1; LdRetAddr = 4'd2; LdRetData = 8'h22; RaddrA = 4'd2;
    #1 check("cf_byp", 32'(DataOutA), 32'h11);
    tick;
    WenAlu = 1'b0; LdRet = 1'b0;
    #1;
    check("cf_data",  32'(DataOutA), 32'h11);
    check("cf_pend0", 32'(Pending), 32'd0);
    check("cf_err0",  32'(ErrSticky), 32'd0);
    check("cf_stall", 32'(Stall), 32'd0);

    // r0 rules
    WenAlu = 1'b1; WaddrAlu = 4'd0; WdataAlu = 8'hFF;
    LdIssue = 1'b1; LdAddr = 4'd0; RaddrA = 4'd0;
    #1;
    check("r0_dout",   32'(DataOutA), 32'h00);
    check("r0_stall",  32'(Stall), 32'd0);
    check("r0_istall", 32'(IssueStall), 32'd0);
    tick;
    WenAlu = 1'b0; LdIssue = 1'b0;
    #1;
    check("r0_dout2", 32'(DataOutA), 32'h00);
    check("r0_pend",  32'(Pending), 32'd0);
    check("nb_r0",    32'(nb_DataOutA), 32'hFF);
    LdRet = 1'b1; LdRetAddr = 4'd0; LdRetData = 8'h77;
    tick;
    LdRet = 1'b0;
    #1;
    check("r0_ret_err", 32'(ErrSticky), 32'd0);
    check("r0_ret_dat", 32'(DataOutA), 32'h00);
    check("nb_r0_ret",  32'(nb_DataOutA), 32'h77);
    check("nb_r0_err",  32'(nb_ErrSticky), 32'd0);

    // WAW on r3 and stray return after ALU overwrite
    LdIssue = 1'b1; LdAddr = 4'd3;
    tick;
    #1 check("waw_istall", 32'(IssueStall), 32'd1);
    tick;
    LdIssue = 1'b0;
    #1 check("waw_pend1", 32'(Pending), 32'd1);
    WenAlu = 1'b1; WaddrAlu = 4'd3; WdataAlu = 8'h33;
    tick;
    WenAlu = 1'b0;
    #1 check("waw_pend0", 32'(Pending), 32'd0);
    LdRet = 1'b1; LdRetAddr = 4'd3; LdRetData = 8'h44;
    tick;
    LdRet = 1'b0; RaddrA = 4'd3;
    #1;
    check("stray_err", 32'(ErrSticky), 32'd1);
    check("stray_dat", 32'(DataOutA), 32'h33);
    tick;
    check("stray_hold", 32'(ErrSticky), 32'd1);

    // Same-cycle re-issue and return on busy r6
    LdIssue = 1'b1; LdAddr = 4'd6;
    tick;
    LdRet = 1'b1; LdRetAddr = 4'd6; LdRetData = 8'h66;
    #1 check("ri_istall", 32'(IssueStall), 32'd0);
    tick;
    LdIssue = 1'b0; LdRet = 1'b0; RaddrA = 4'd6;
    #1;
    check("ri_pend",  32'(Pending), 32'd1);
    check("ri_data",  32'(DataOutA), 32'h66);
    check("ri_stall", 32'(Stall), 32'd1);
    LdRet = 1'b1; LdRetData = 8'h67;
    tick;
    LdRet = 1'b0;
    #1;
    check("ri_pend0", 32'(Pending), 32'd0);
    check("ri_data2", 32'(DataOutA), 32'h67);

    // Issue and stray return on idle r8 in the same cycle
    LdIssue = 1'b1; LdAddr = 4'd8;
    LdRet = 1'b1; LdRetAddr = 4'd8; LdRetData = 8'h88;
    tick;
    LdIssue = 1'b0; LdRet = 1'b0; RaddrA = 4'd8;
    #1;
    check("ir_pend",  32'(Pending), 32'd1);
    check("ir_data",  32'(DataOutA), 32'h00);
    check("ir_stall", 32'(Stall), 32'd1);

    // Asynchronous reset mid-run
    RaddrA = 4'd5;
    #1 check("pre_rst_r5", 32'(DataOutA), 32'h3C);
    ResetN = 1'b0;
    #1;
    check("mrst_r5",   32'(DataOutA), 32'h00);
    check("mrst_pend", 32'(Pending), 32'd0);
    check("mrst_err",  32'(ErrSticky), 32'd0);
    check("mrst_stall", 32'(Stall), 32'd0);
    #1 ResetN = 1'b1;
    LdRet = 1'b1; LdRetAddr = 4'd8; LdRetData = 8'h99;
    tick;
    LdRet = 1'b0; RaddrA = 4'd8;
    #1;
    check("post_rst_stray", 32'(ErrSticky), 32'd1);
    check("post_rst_r8",    32'(DataOutA), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_scb.md
Name: reg_file_scb

Overview:
- Parametrised next-generation register file for the FASA datapath.
- Provides two independently addressed read ports, one ALU write port and one load-return write port, with same-cycle write bypass and optional read-as-zero r0.
- Adds a per-register load scoreboard: pending loads mark their destination busy, and reads of busy registers raise stall.
- Sits between decode, the ALU and the data-memory return path.

Parameters:
- W, 8: data path width.
- A, 4: address width; depth is 2**A registers.
- ZERO_R0, 1: 1 makes r0 read-as-zero with writes ignored; 0 makes r0 general purpose.
- BYPASS, 1: 1 means a read returns same-cycle write data; 0 means a read returns the stored value only.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- RaddrA  in  A  read port A address.
- RaddrB  in  A  read port B address.
- DataOutA  out  W  port A data (combinational).
- DataOutB  out  W  port B data (combinational).
- WenAlu  in  1  ALU write enable.
- WaddrAlu  in  A  ALU write address.
- WdataAlu  in  W  ALU write data.
- LdIssue  in  1  load issued; marks LdAddr busy.
- LdAddr  in  A  destination of the issued load.
- LdRet  in  1  load data return valid.
- LdRetAddr  in  A  destination of the returned load.
- LdRetData  in  W  returned load data.
- Stall  out  1  RaddrA or RaddrB is busy.
- IssueStall  out  1  LdIssue targets an already-busy register; the issue is ignored.
- Pending  out  A+1  count of busy registers.
- ErrSticky  out  1  a stray load return occurred; cleared only by reset.

Behaviour:
- Reset (asynchronous, ResetN=0): all registers 0, busy vector 0, Pending=0, ErrSticky=0. DataOutA/B=0 and Stall=IssueStall=0 as long as inputs do not write.
- Reset mid-operation discards all outstanding loads. Any LdRet arriving after release counts as stray.
- Reads are combinational, with zero latency.
- Read with ZERO_R0=1 and address 0: returns 0 and is never busy.
- Read with BYPASS=1: if a write this cycle targets the read address, that write's data is returned, resolved with the same priority as the write below. Otherwise the stored value is returned.
- Writes take effect on the rising edge of Clk.
- Write priority, both ports targeting the same address in one cycle: the ALU write wins (it is program-younger), and the busy bit is cleared.
- Load return (LdRet), busy target: writes LdRetData and clears the busy bit.
- Load return, non-busy target: the write is dropped and ErrSticky sets.
- LdRet to r0 with ZERO_R0=1 is always dropped silently, with no error.
- ALU write to a busy register: data is written, the busy bit is cleared, and the later load return becomes stray.
- LdIssue to a non-busy register (not r0 with ZERO_R0=1): sets busy at the edge. LdIssue to r0 with ZERO_R0=1 is ignored.
- LdIssue to a busy register: IssueStall=1 combinationally, and there is no state change.
- Simultaneous LdIssue and LdRet to the same address:
  - Address busy: the return writes its data and busy stays set for the new load. Net Pending change 0; IssueStall=0.
  - Address not busy: the issue sets busy and the return counts as stray.
- Stall = (busy[RaddrA] | busy[RaddrB]). A read bypassed by this cycle's clearing write does not count as busy.
- Pending increments on an accepted issue and decrements on each busy clear.
  - Simultaneous increment and decrement: no net change.
  - Maximum value 2**A, or 2**A-1 when ZERO_R0=1; saturation cannot be reached by construction.
- Per-register busy state: IDLE -> BUSY on an accepted issue. BUSY -> IDLE on a load return or ALU write, unless re-issued in the same cycle.

Decomposition:
- Shared Definitions package holds:
  - busy state enum (IDLE, BUSY);
  - constant kRegZero=0;
  - existing opcode constants (kLOD etc.), which decode uses to drive LdIssue/WenAlu.
- One sub-module, reg_scoreboard: busy vector, Pending counter, IssueStall/ErrSticky generation.
- The top level holds the storage array, write arbitration and read/bypass muxes.

Test Plan:
- Reset/read-zero: pulse ResetN=0 mid-run after writing r5=0x3C -> DataOutA(r5)=0x00, Pending=0, ErrSticky=0 without waiting for a clock edge.
- Bypass: WenAlu to r4 with 0xA5, RaddrA=4 in the same cycle -> DataOutA=0xA5 before the edge (BYPASS=1). With BYPASS=0 it shows the old value, then 0xA5 after the edge.
- Scoreboard: LdIssue r7 -> Pending=1. RaddrB=7 -> Stall=1. LdRet r7 with 0x5A -> Stall=0 next cycle, DataOutB=0x5A, Pending=0.
- Conflict: same cycle WenAlu r2=0x11 and LdRet r2=0x22 with r2 busy -> r2=0x11, busy cleared, ErrSticky stays 0.
- Stray/WAW:
  - LdIssue r3 twice -> second IssueStall=1, Pending=1.
  - ALU write to r3, then LdRet r3 -> return dropped, ErrSticky=1 until reset.
- r0 rule (ZERO_R0=1): WenAlu r0=0xFF, LdIssue r0 -> DataOutA(r0)=0, Stall=0, Pending unchanged.
